// File: rtl/eth_tx_sched.sv
// eth_tx_sched: round-robin owner of the single MAC TX port.
// Chooses one of N frame producers, sends the MAC a one-cycle start strobe
// and grant, and keeps ownership for the whole frame. While the frame is
// active it steers the owner's byte stream to the MAC. Afterwards it holds
// an inter-frame gap before the next selection. A MAC that never raises
// tx_busy after the start strobe is abandoned after TO cycles.
// Optional build macro: ETH_TX_SCHED_STRICT0_EN gives requester 0 (ARP)
// strict priority over the round-robin among the other requesters.
module eth_tx_sched #(
    parameter int N   = 2,
    parameter int CW  = 11,
    parameter int GAP = 24,
    parameter int TO  = 1023
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [N-1:0]                        req,
    input  logic [N*CW-1:0]                     req_count,
    output logic [N-1:0]                        grant,
    input  logic [N*8-1:0]                      req_data,
    output logic                                tx_vld,
    output logic [CW-1:0]                       tx_count,
    output logic [7:0]                          tx_data,
    input  logic                                tx_busy,
    input  logic                                tx_adv,
    input  logic                                tx_last,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] owner,
    output logic                                sched_busy,
    output logic                                timeout
);

    localparam int OW   = (N > 1) ? $clog2(N) : 1;
    localparam int CMAX = (TO > GAP) ? TO : GAP;
    localparam int CNTW = $clog2(CMAX + 2);

    // Last count value of the start wait and of the gap; a zero setting
    // collapses to a single evaluation cycle (GAP=0 never enters the gap).
    localparam logic [CNTW-1:0] TO_LIM  = CNTW'((TO > 0) ? TO - 1 : 0);
    localparam logic [CNTW-1:0] GAP_LIM = CNTW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [CNTW-1:0] cnt;
    logic            found;
    logic            upd_ptr;
    logic [OW-1:0]   win;
    logic [OW:0]     sum;
    logic [OW-1:0]   cand;

    // Winner search: first set request after the pointer, wrapping modulo N.
    always_comb begin
        found   = 1'b0;
        upd_ptr = 1'b0;
        win     = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr} + (OW+1)'(k);
            if (sum >= (OW+1)'(N)) begin
                sum = sum - (OW+1)'(N);
            end
            cand = sum[OW-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        upd_ptr = found;
`ifdef ETH_TX_SCHED_STRICT0_EN
        // ARP wins outright and leaves the rotation of the others untouched.
        if (req[0]) begin
            win     = '0;
            upd_ptr = 1'b0;
        end
`endif
    end

    // Scheduler state machine with registered grant, strobe and timeout pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            ptr      <= OW'(N - 1);
            owner    <= '0;
            tx_count <= '0;
            cnt      <= '0;
            grant    <= '0;
            tx_vld   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            grant   <= '0;
            tx_vld  <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found && !tx_busy) begin
                        owner    <= win;
                        tx_count <= req_count[win*CW +: CW];
                        if (upd_ptr) begin
                            ptr <= win;
                        end
                        state <= S_START;
                    end
                end
                S_START: begin
                    tx_vld <= 1'b1;
                    grant  <= {{(N-1){1'b0}}, 1'b1} << owner;
                    cnt    <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_busy) begin
                        if (tx_adv && tx_last) begin
                            cnt   <= '0;
                            state <= (GAP == 0) ? S_IDLE : S_GAP;
                        end else begin
                            state <= S_ACTIVE;
                        end
                    end else if (cnt >= TO_LIM) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if ((tx_adv && tx_last) || !tx_busy) begin
                        cnt   <= '0;
                        state <= (GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (cnt >= GAP_LIM) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte steering: only the active owner's stream reaches the MAC.
    always_comb begin
        tx_data = 8'h00;
        if (state == S_ACTIVE) begin
            tx_data = req_data[owner*8 +: 8];
        end
    end

    assign sched_busy = (state != S_IDLE);

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb_eth_tx_sched: randomized self-checking bench for eth_tx_sched.
// Acts as the requesters and the MAC; a round-robin reference model
// predicts every grant. Honours ETH_TX_SCHED_STRICT0_EN when defined.
module tb_eth_tx_sched;

    localparam int N   = 3;
    localparam int CW  = 11;
    localparam int GAP = 24;
    localparam int TO  = 15;
    localparam int OW  = 2;

    logic            clk       = 1'b0;
    logic            resetn    = 1'b0;
    logic [N-1:0]    req       = '0;
    logic [N*CW-1:0] req_count = '0;
    logic [N*8-1:0]  req_data  = '0;
    logic            tx_busy   = 1'b0;
    logic            tx_adv    = 1'b0;
    logic            tx_last   = 1'b0;
    logic [N-1:0]    grant;
    logic            tx_vld;
    logic [CW-1:0]   tx_count;
    logic [7:0]      tx_data;
    logic [OW-1:0]   owner;
    logic            sched_busy;
    logic            timeout;

    int total     = 0;
    int bad       = 0;
    int model_ptr = N - 1;

    always #5 clk = ~clk;

    eth_tx_sched #(.N(N), .CW(CW), .GAP(GAP), .TO(TO)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .req_count  (req_count),
        .grant      (grant),
        .req_data   (req_data),
        .tx_vld     (tx_vld),
        .tx_count   (tx_count),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_adv     (tx_adv),
        .tx_last    (tx_last),
        .owner      (owner),
        .sched_busy (sched_busy),
        .timeout    (timeout)
    );

    // Reference arbitration: first requester after the last winner, cyclically.
    function automatic int predict(input logic [N-1:0] m, input int p);
        int w;
        w = -1;
`ifdef ETH_TX_SCHED_STRICT0_EN
        if (m[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (w < 0 && m[(p + k) % N]) w = (p + k) % N;
        end
        return w;
    endfunction

    function automatic void advance(input int w);
`ifdef ETH_TX_SCHED_STRICT0_EN
        if (w == 0) return;
`endif
        model_ptr = w;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0 && w < N) v[w] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_counts();
        for (int i = 0; i < N; i++) req_count[i*CW +: CW] = CW'($urandom_range(1, 1500));
    endtask

    // Waits (bounded) for the start strobe; lat=-1 when it never comes.
    task automatic wait_vld(output int lat, output logic [N-1:0] g,
                            output logic [OW-1:0] o, output logic [CW-1:0] c);
        lat = -1; g = '0; o = '0; c = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (tx_vld) begin
                lat = i; g = grant; o = owner; c = tx_count;
                break;
            end
        end
    endtask

    // MAC side of one frame, from the strobe cycle until the scheduler idles.
    task automatic mac_frame(input int bdelay, input int nbytes, input int exp_o,
                             output int data_bad, output int gap_len, output int vld_bad);
        data_bad = 0; vld_bad = 0; gap_len = -1;
        for (int i = 0; i < bdelay; i++) begin
            req_data = N*8'($urandom);
            #1;
            if (tx_data !== 8'h00) data_bad++;
            tick();
        end
        tx_busy = 1'b1;
        tick();
        for (int i = 0; i < nbytes; i++) begin
            req_data = N*8'($urandom);
            tx_adv   = 1'b1;
            tx_last  = (i == nbytes - 1);
            #1;
            if (tx_data !== req_data[exp_o*8 +: 8]) data_bad++;
            tick();
        end
        tx_adv = 1'b0; tx_last = 1'b0; tx_busy = 1'b0;
        for (int i = 0; i <= 100; i++) begin
            if (!sched_busy) begin
                gap_len = i;
                break;
            end
            req_data = N*8'($urandom);
            #1;
            if (tx_data !== 8'h00) data_bad++;
            if (tx_vld) vld_bad++;
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = '0; req_data = {N{8'h5A}};
        repeat (3) tick();
        model_ptr = N - 1;
        total++; if (grant !== '0) begin bad++; $display("[TB] FAIL reset_grant: got %0h want 0", grant); end
        total++; if (tx_vld !== 1'b0) begin bad++; $display("[TB] FAIL reset_vld: got %0b want 0", tx_vld); end
        total++; if (tx_count !== '0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", tx_count); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data: got %0h want 0", tx_data); end
        total++; if (owner !== '0) begin bad++; $display("[TB] FAIL reset_owner: got %0d want 0", owner); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", sched_busy); end
        total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %0b want 0", timeout); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int lat, db, gl, vb, w;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        set_counts();
        req_count[1*CW +: CW] = CW'(60);
        req = 3'b010;
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL single_latency: got %0d want 2", lat); end
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL single_grant: got %0h want %0h", g, onehot(w)); end
        total++; if (o !== OW'(w)) begin bad++; $display("[TB] FAIL single_owner: got %0d want %0d", o, w); end
        total++; if (c !== CW'(60)) begin bad++; $display("[TB] FAIL single_count: got %0d want 60", c); end
        mac_frame(3, 60, w, db, gl, vb);
        total++; if (db !== 0) begin bad++; $display("[TB] FAIL single_data: got %0d bad bytes want 0", db); end
        total++; if (gl !== GAP) begin bad++; $display("[TB] FAIL single_gap: got %0d want %0d", gl, GAP); end
        total++; if (vb !== 0) begin bad++; $display("[TB] FAIL single_vld_in_gap: got %0d want 0", vb); end
    endtask

    task automatic test_round_robin();
        int lat, db, gl, vb, w;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c, ec;
        for (int f = 0; f < 16; f++) begin
            req = req | N'($urandom_range(1, (1 << N) - 1));
            set_counts();
            w  = predict(req, model_ptr);
            ec = req_count[w*CW +: CW];
            wait_vld(lat, g, o, c);
            req[w] = 1'b0;
            advance(w);
            total++; if (lat !== 2) begin bad++; $display("[TB] FAIL rr_latency f%0d: got %0d want 2", f, lat); end
            total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL rr_grant f%0d: got %0h want %0h", f, g, onehot(w)); end
            total++; if (o !== OW'(w)) begin bad++; $display("[TB] FAIL rr_owner f%0d: got %0d want %0d", f, o, w); end
            total++; if (c !== ec) begin bad++; $display("[TB] FAIL rr_count f%0d: got %0d want %0d", f, c, ec); end
            mac_frame($urandom_range(0, 3), $urandom_range(1, 8), w, db, gl, vb);
            total++; if (db !== 0) begin bad++; $display("[TB] FAIL rr_data f%0d: got %0d bad bytes want 0", f, db); end
            total++; if (gl !== GAP) begin bad++; $display("[TB] FAIL rr_gap f%0d: got %0d want %0d", f, gl, GAP); end
            total++; if (vb !== 0) begin bad++; $display("[TB] FAIL rr_vld_in_gap f%0d: got %0d want 0", f, vb); end
        end
        req = '0;
    endtask

    task automatic test_busy_in_idle();
        int lat, db, gl, vb, w, early;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        set_counts();
        tx_busy = 1'b1;
        req = 3'b001;
        early = 0;
        repeat (6) begin
            tick();
            if (tx_vld || grant !== '0 || sched_busy) early++;
        end
        total++; if (early !== 0) begin bad++; $display("[TB] FAIL busy_idle_hold: got %0d active cycles want 0", early); end
        tx_busy = 1'b0;
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL busy_idle_latency: got %0d want 2", lat); end
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL busy_idle_grant: got %0h want %0h", g, onehot(w)); end
        mac_frame(1, 3, w, db, gl, vb);
        total++; if (db !== 0 || gl !== GAP) begin bad++; $display("[TB] FAIL busy_idle_frame: got data_bad=%0d gap=%0d want 0/%0d", db, gl, GAP); end
    endtask

    task automatic test_timeout();
        int lat, db, gl, vb, w, r, tcnt;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        r = $urandom_range(0, N - 1);
        set_counts();
        req = onehot(r);
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL to_grant: got %0h want %0h", g, onehot(w)); end
        tcnt = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (timeout) begin
                tcnt = i;
                break;
            end
        end
        total++; if (tcnt !== TO) begin bad++; $display("[TB] FAIL to_delay: got %0d want %0d", tcnt, TO); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("[TB] FAIL to_idle: got %0b want 0", sched_busy); end
        tick();
        total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse_width: got %0b want 0", timeout); end
        req = '1;
        set_counts();
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req[w] = 1'b0;
        advance(w);
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL to_next_grant: got %0h want %0h", g, onehot(w)); end
        mac_frame(0, 2, w, db, gl, vb);
        req = '0;
        total++; if (db !== 0 || gl !== GAP) begin bad++; $display("[TB] FAIL to_frame: got data_bad=%0d gap=%0d want 0/%0d", db, gl, GAP); end
    endtask

    task automatic test_drop_before_start();
        int lat, db, gl, vb, w;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        w = $urandom_range(0, N - 1);
        set_counts();
        req = onehot(w);
        tick();
        req = '0;
        wait_vld(lat, g, o, c);
        advance(w);
        total++; if (lat !== 1) begin bad++; $display("[TB] FAIL drop_latency: got %0d want 1", lat); end
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL drop_grant: got %0h want %0h", g, onehot(w)); end
        mac_frame(0, 2, w, db, gl, vb);
        total++; if (db !== 0 || gl !== GAP) begin bad++; $display("[TB] FAIL drop_frame: got data_bad=%0d gap=%0d want 0/%0d", db, gl, GAP); end
    endtask

    task automatic test_reset_mid_frame();
        int lat, db, gl, vb, w;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        w = $urandom_range(1, N - 1);
        set_counts();
        req = onehot(w);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL rst_mid_grant: got %0h want %0h", g, onehot(w)); end
        tx_busy = 1'b1;
        tick();
        db = 0;
        for (int i = 0; i < 10; i++) begin
            req_data = N*8'($urandom);
            tx_adv = 1'b1;
            #1;
            if (tx_data !== req_data[w*8 +: 8]) db++;
            tick();
        end
        total++; if (db !== 0) begin bad++; $display("[TB] FAIL rst_mid_data: got %0d bad bytes want 0", db); end
        resetn = 1'b0; tx_adv = 1'b0; tx_busy = 1'b0; req_data = {N{8'h5A}};
        tick();
        model_ptr = N - 1;
        total++; if (tx_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_mid_txdata: got %0h want 0", tx_data); end
        total++; if (tx_vld !== 1'b0 || grant !== '0) begin bad++; $display("[TB] FAIL rst_mid_strobe: got vld=%0b grant=%0h want 0/0", tx_vld, grant); end
        total++; if (owner !== '0) begin bad++; $display("[TB] FAIL rst_mid_owner: got %0d want 0", owner); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy: got %0b want 0", sched_busy); end
        resetn = 1'b1;
        req = 3'b001;
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (lat !== 2) begin bad++; $display("[TB] FAIL rst_mid_relatency: got %0d want 2", lat); end
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL rst_mid_regrant: got %0h want %0h", g, onehot(w)); end
        mac_frame(2, 5, w, db, gl, vb);
        total++; if (db !== 0 || gl !== GAP) begin bad++; $display("[TB] FAIL rst_mid_frame: got data_bad=%0d gap=%0d want 0/%0d", db, gl, GAP); end
    endtask

`ifdef ETH_TX_SCHED_STRICT0_EN
    task automatic test_strict0();
        int lat, db, gl, vb, w;
        logic [N-1:0] g; logic [OW-1:0] o; logic [CW-1:0] c;
        req = '1;
        for (int f = 0; f < 4; f++) begin
            set_counts();
            wait_vld(lat, g, o, c);
            advance(0);
            total++; if (g !== 3'b001) begin bad++; $display("[TB] FAIL strict_grant f%0d: got %0h want 1", f, g); end
            mac_frame(0, 2, 0, db, gl, vb);
        end
        req = 3'b110;
        w = predict(req, model_ptr);
        wait_vld(lat, g, o, c);
        req = '0;
        advance(w);
        total++; if (g !== onehot(w)) begin bad++; $display("[TB] FAIL strict_release: got %0h want %0h", g, onehot(w)); end
        mac_frame(0, 2, w, db, gl, vb);
    endtask
`endif

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_busy_in_idle();
        test_timeout();
        test_drop_before_start();
        test_reset_mid_frame();
`ifdef ETH_TX_SCHED_STRICT0_EN
        test_strict0();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
Round-robin scheduler that shares the single MAC TX port among N frame producers (ARP responder, UDP TX, future ICMP).
- Replaces the fixed-priority combinational mux at top level.
- Issues one-cycle grants and the MAC start strobe.
- Locks ownership for the whole frame.
- Steers the owner's byte stream to the MAC.
- Enforces an inter-frame gap and recovers from a MAC that never starts.

Parameters:
N, 2, number of requesters (2..8); index 0 is the ARP port.
CW, 11, frame byte-count width.
GAP, 24, idle cycles enforced after each frame end (0 allowed).
TO, 1023, max cycles waiting for tx_busy after the start strobe before abort.

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active-low
req  in  N  per-requester frame request, level, held until granted
req_count  in  N*CW  per-requester byte count, slice i = bits [i*CW +: CW]
grant  out  N  one-hot one-cycle grant pulse
req_data  in  N*8  per-requester TX byte, slice i = bits [i*8 +: 8]
tx_vld  out  1  MAC start strobe, one cycle
tx_count  out  CW  byte count to MAC, valid with tx_vld, held through the frame
tx_data  out  8  owner's req_data slice while owned, else 0
tx_busy  in  1  MAC transmitting
tx_adv  in  1  MAC consumed a byte
tx_last  in  1  with tx_adv: final byte
owner  out  $clog2(N) max 1  current or last owner index
sched_busy  out  1  state != IDLE
timeout  out  1  one-cycle pulse on start-timeout abort

Behaviour:
Reset: all outputs 0, state IDLE, RR pointer = N-1 so requester 0 wins first, counters 0. Reset applies on any cycle, including mid-frame. After reset, tx_data is 0 immediately and no grant is re-issued until a fresh IDLE evaluation.

States: IDLE, START, WAIT, ACTIVE, GAP.

IDLE:
- If any req is set and tx_busy=0, select the first set req searching from pointer+1 upward, wrapping modulo N.
- Register owner, tx_count = that req_count slice, pointer = winner.
- Next cycle: state START.
- If tx_busy=1 (foreign or stale activity), stay IDLE.

START (exactly 1 cycle):
- tx_vld=1 and grant[owner]=1, both registered outputs.
- Go to WAIT.
- Latency from req assertion to grant/tx_vld is 2 cycles.

WAIT:
- tx_busy=1 -> ACTIVE.
- Cycle counter reaches TO -> pulse timeout, go IDLE; pointer keeps the winner.
- tx_busy=1 and tx_adv&tx_last in the same cycle -> straight to GAP.

ACTIVE:
- tx_data = req_data[owner] (combinational mux on registered owner).
- tx_adv&tx_last -> GAP.
- tx_busy falls without last -> abort to GAP.

GAP:
- Count GAP cycles, then IDLE. GAP=0 skips directly to IDLE.
- req is ignored throughout.

General rules:
- grant is never asserted in more than one bit.
- tx_vld never asserts outside START.
- tx_data is 0 in IDLE, START, WAIT and GAP.
- A req dropped by its requester after selection but before START is still granted; the requester must tolerate this.
- tx_count holds its value until the next selection.
- Counters saturate and never wrap.

Optional Feature:
Macro: ETH_TX_SCHED_STRICT0_EN
- Defined: requester 0 (ARP) has strict priority. In IDLE, if req[0]=1 it wins regardless of pointer, and the pointer is not updated. Other requesters use round-robin among themselves.
- Undefined: pure round-robin across all N.

Test Plan:
1. N=2, req[1]=1 only, req_count[1]=60, tx_busy rises 3 cycles after tx_vld, 60 tx_adv with last on the 60th -> grant=2'b10 and tx_vld at cycle 2, tx_count=60, tx_data tracks req_data[1], sched_busy falls 24 cycles after last.
2. req=2'b11 held for 4 frames -> grant order 0,1,0,1; owner matches each grant; no tx_vld during GAP.
3. tx_busy=1 in IDLE with req[0]=1 -> no grant until tx_busy drops, then grant 2 cycles later.
4. TO=15, grant issued, tx_busy held 0 -> timeout pulse 15 cycles after START, state IDLE; next grant goes to the other requester if it is requesting.
5. resetn=0 mid-ACTIVE (byte 10 of 60) -> next cycle tx_data=0, tx_vld=0, grant=0, owner=0; with req[0]=1 after release, grant[0] fires 2 cycles later.
6. ETH_TX_SCHED_STRICT0_EN defined, req=2'b11 continuous -> requester 0 granted every frame, requester 1 never; drop req[0] -> requester 1 granted next.
